tx_scrambler: RTL and testbench
===============================

Name: tx_scrambler

Overview:
- PCIe MAC TX data-path scrambler. It sits directly downstream of the scrambler control stage.
- It consumes that stage's per-byte advance, scrambling-enable, pattern-reset and LFSR-width-select controls. It applies the Gen1/2 16-bit or Gen3 23-bit LFSR to the PIPE TX word.
- Output is registered toward the PIPE interface. One instance per lane.

Parameters:
- LANE_NUM, 0, lane index 0-7; selects the Gen3 LFSR seed.
- SEED_G12, 16'hFFFF, Gen1/2 LFSR seed.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- gen  in  3  link generation (1/2/3); <3 selects the Gen1/2 scrambler.
- lfsr_sel  in  2  0 = 8-bit PIPE, 1 = 16-bit, 2 = 32-bit (3 treated as 2).
- pattern_reset  in  1  reload LFSR seed after the current word.
- advance  in  4  per-byte LFSR advance enable (0 = SKP byte, no advance).
- scrambling_enable  in  4  per-byte scramble enable (Gen3).
- in_valid  in  1  input word valid.
- in_data  in  32  TX symbols; byte 0 = [7:0] is first in time.
- in_datak  in  4  per-byte K flag (Gen1/2).
- in_sync_header  in  2  Gen3 sync header, passed through unmodified.
- out_valid  out  1  registered in_valid.
- out_data  out  32  scrambled word.
- out_datak  out  4  registered in_datak.
- out_sync_header  out  2  registered in_sync_header.

Behaviour:
- Reset values:
  - out_valid, out_data, out_datak, out_sync_header = 0.
  - LFSR = SEED_G12 when gen<3, else the Gen3 seed of LANE_NUM.
  - Gen3 seeds, lanes 0-7: 1DBFBC, 0607BB, 1EC760, 18C0DB, 010F12, 19CFC9, 0277CE, 1BB807.
  - Reset has priority over every other input, including mid-word.
- Latency: exactly 1 cycle. No backpressure. When in_valid=0, outputs hold, out_valid=0, and the LFSR does not change.
- Active bytes: N = 1/2/4 per lfsr_sel. Bytes >= N pass through unscrambled and never advance the LFSR.
- Bytes are processed serially within a cycle, byte 0 to byte N-1. Each byte i sees the LFSR state left by bytes < i.
- Gen1/2 scrambling:
  - Polynomial x^16+x^5+x^4+x^3+1, Galois form.
  - Output bit j of byte i = in bit j XOR LFSR bit 15 before the j-th shift (LSB first).
  - Scrambled iff advance[i]=1 AND in_datak[i]=0.
  - LFSR shifts 8 times iff advance[i]=1; K symbols still advance unless SKP (advance=0).
- Gen3 scrambling:
  - Polynomial x^23+x^21+x^16+x^8+x^5+x^2+1, Galois form.
  - Byte scrambled iff scrambling_enable[i]=1; in_datak is ignored.
  - LFSR shifts 8 times iff advance[i]=1.
- pattern_reset:
  - With in_valid=1, the current word is processed normally.
  - The next-cycle LFSR is loaded with the seed for the current gen; the computed advance result is discarded.
  - pattern_reset takes precedence over advance in the same cycle.
- gen change: takes effect on the next valid word. The LFSR is not reloaded automatically; the control stage issues pattern_reset.
- State: no FSM beyond the LFSR register (24 bits wide, Gen1/2 uses the low 16).
- Arithmetic: XOR only; no carry or overflow.

Optional Feature:
- Macro TX_SCR_DISABLE_EN.
- Defined:
  - Adds input port scr_disable (1 bit), for the training "disable scrambling" control.
  - When 1, out_data = in_data for all bytes. LFSR advance and reset behaviour is unchanged.
- Undefined: the port is absent and scrambling is always per the rules above.

Decomposition:
- Shared package tx_scr_pkg holds:
  - polynomial tap constants for both generations;
  - SEED_G12 and the Gen3 seed array;
  - lfsr_sel encodings;
  - byte-step functions: next LFSR state after 8 shifts, and 8-bit keystream.
- Sub-module tx_scr_byte (combinational):
  - inputs: one byte, lfsr, gen, adv, en;
  - outputs: scrambled byte and next lfsr.
  - Instantiated 4x in a chain by tx_scrambler.

Test Plan:
- Gen1 after reset, lfsr_sel=0, in_data=00, advance=1, K=0, 8 valid words -> out bytes FF,17,C0,14,B2,E7,02,82.
- Gen1, lfsr_sel=2, in_data=32'h0000_0000, advance=F -> out_data=32'h14C017FF; next word -> 32'h8202E7B2.
- Gen1 word 1C1C1CBC, K=F, advance=4'b0001 with pattern_reset=1, followed by zero data -> SKP/COM pass unscrambled; next output byte 0 = FF.
- Gen3 lane 0 and lane 5, lfsr_sel=2, scrambling_enable=F, zero data for 64 words -> bit-exact match to the package golden function; scrambling_enable=0 word -> out=in while the LFSR still advances.
- in_valid=0 for 3 cycles in the middle of a Gen1 stream -> sequence resumes without gaps; reset asserted mid-stream -> all outputs 0 and next keystream byte FF.
- With TX_SCR_DISABLE_EN, scr_disable=1 for 2 words then 0 -> first two outputs equal the input; third word's keystream equals the third word of the undisabled stream.

Source files
------------

// File: rtl/tx_scr_pkg.sv
// Shared definitions for the PCIe TX scrambler: LFSR taps, seeds,
// lfsr_sel encodings, the TX word bundle and the per-byte LFSR step helpers.
package tx_scr_pkg;

  // Galois feedback taps, without the x^N term
  localparam logic [15:0] G12_TAPS     = 16'h0039;   // x^5+x^4+x^3+1
  localparam logic [22:0] G3_TAPS      = 23'h210125; // x^21+x^16+x^8+x^5+x^2+1
  localparam logic [15:0] G12_SEED_DEF = 16'hFFFF;

  // Gen3 per-lane seeds, lane 0 first
  localparam logic [0:7][22:0] G3_SEED = {
    23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
    23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807
  };

  localparam logic [1:0] LSEL_8  = 2'd0;
  localparam logic [1:0] LSEL_16 = 2'd1;
  localparam logic [1:0] LSEL_32 = 2'd2;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  datak;
    logic [1:0]  sync_header;
  } tx_word_t;

  function automatic logic is_gen3(logic [2:0] gen);
    return gen >= 3'd3;
  endfunction

  // Bytes taking part in scrambling for a PIPE width; code 3 behaves as 32-bit
  function automatic logic [3:0] active_mask(logic [1:0] sel);
    case (sel)
      LSEL_8:  return 4'b0001;
      LSEL_16: return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [22:0] g3_seed(logic [2:0] lane);
    return G3_SEED[lane];
  endfunction

  function automatic logic [4:0] lfsr_msb(logic g3);
    return g3 ? 5'd22 : 5'd15;
  endfunction

  function automatic logic [23:0] lfsr_mask(logic g3);
    return g3 ? 24'h7FFFFF : 24'h00FFFF;
  endfunction

  function automatic logic [23:0] lfsr_taps(logic g3);
    return g3 ? {1'b0, G3_TAPS} : {8'h00, G12_TAPS};
  endfunction

  // One Galois shift: feedback from the MSB of the active width
  function automatic logic [23:0] lfsr_shift1(logic [23:0] s, logic g3);
    logic [23:0] n;
    n = (s << 1) & lfsr_mask(g3);
    if (s[lfsr_msb(g3)]) n = n ^ lfsr_taps(g3);
    return n;
  endfunction

  function automatic logic [23:0] lfsr_step8(logic [23:0] s, logic g3);
    logic [23:0] t;
    t = s;
    for (int j = 0; j < 8; j++) t = lfsr_shift1(t, g3);
    return t;
  endfunction

  // Keystream bit j is the MSB before the j-th shift (LSB of the byte first)
  function automatic logic [7:0] keystream8(logic [23:0] s, logic g3);
    logic [7:0]  k;
    logic [23:0] t;
    t = s;
    k = '0;
    for (int j = 0; j < 8; j++) begin
      k[j] = t[lfsr_msb(g3)];
      t    = lfsr_shift1(t, g3);
    end
    return k;
  endfunction

endpackage

// File: rtl/tx_scrambler_if.sv
// TX word bus between the scrambler control stage, the scrambler and PIPE.
interface tx_scrambler_if;
  logic        valid;
  logic [31:0] data;
  logic [3:0]  datak;
  logic [1:0]  sync_header;

  modport master (output valid, data, datak, sync_header);
  modport slave  (input  valid, data, datak, sync_header);
endinterface

// File: rtl/tx_scr_byte.sv
// One byte slice of the scrambler chain: XOR with keystream when enabled,
// hand the (possibly advanced) LFSR state to the next byte.
module tx_scr_byte
  import tx_scr_pkg::*;
(
  input  logic [7:0]  din,
  input  logic [23:0] lfsr,
  input  logic [2:0]  gen,
  input  logic        adv,
  input  logic        en,
  output logic [7:0]  dout,
  output logic [23:0] lfsr_nxt
);
  logic g3;

  // keystream depends only on the incoming state, so a non-advancing
  // scrambled byte still sees the correct bits
  always_comb begin
    g3       = is_gen3(gen);
    dout     = en  ? (din ^ keystream8(lfsr, g3)) : din;
    lfsr_nxt = adv ? lfsr_step8(lfsr, g3) : lfsr;
  end
endmodule

// File: rtl/tx_scrambler.sv
// PCIe MAC TX scrambler, one per lane. Gen1/2 16-bit or Gen3 23-bit LFSR
// applied serially over the active bytes of the PIPE word, 1-cycle latency.
// Optional build macro TX_SCR_DISABLE_EN adds the scr_disable input.
module tx_scrambler
  import tx_scr_pkg::*;
#(
  parameter int unsigned LANE_NUM = 0,
  parameter logic [15:0] SEED_G12 = G12_SEED_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  gen,
  input  logic [1:0]  lfsr_sel,
  input  logic        pattern_reset,
  input  logic [3:0]  advance,
  input  logic [3:0]  scrambling_enable,
`ifdef TX_SCR_DISABLE_EN
  input  logic        scr_disable,
`endif
  tx_scrambler_if.slave  in_if,
  tx_scrambler_if.master out_if
);
  localparam int          NB      = 4;
  localparam logic [22:0] SEED_G3 = g3_seed(3'(LANE_NUM));

  logic [NB:0][23:0]  chain;
  logic [NB-1:0][7:0] sbyte;
  logic [NB-1:0]      act, adv_b, en_b;
  logic [23:0]        lfsr, seed_cur;
  logic               g3, scr_dis;
  logic               vld_q;
  tx_word_t           out_q;

`ifdef TX_SCR_DISABLE_EN
  assign scr_dis = scr_disable;
`else
  assign scr_dis = 1'b0;
`endif

  assign g3       = is_gen3(gen);
  assign seed_cur = g3 ? {1'b0, SEED_G3} : {8'h00, SEED_G12};
  assign act      = active_mask(lfsr_sel);
  assign chain[0] = lfsr;

  // Byte chain: byte i starts from the state left by bytes below it.
  // Inactive bytes neither scramble nor advance.
  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign adv_b[i] = act[i] & advance[i];
    assign en_b[i]  = act[i] & ~scr_dis &
                      (g3 ? scrambling_enable[i] : (advance[i] & ~in_if.datak[i]));
    tx_scr_byte u_byte (
      .din      (in_if.data[8*i +: 8]),
      .lfsr     (chain[i]),
      .gen      (gen),
      .adv      (adv_b[i]),
      .en       (en_b[i]),
      .dout     (sbyte[i]),
      .lfsr_nxt (chain[i+1])
    );
  end

  // Register the word toward PIPE; LFSR moves only on valid words and a
  // pattern_reset replaces the advanced state with the seed
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr  <= seed_cur;
      vld_q <= 1'b0;
      out_q <= '0;
    end else begin
      vld_q <= in_if.valid;
      if (in_if.valid) begin
        out_q.data        <= sbyte;
        out_q.datak       <= in_if.datak;
        out_q.sync_header <= in_if.sync_header;
        lfsr              <= pattern_reset ? seed_cur : chain[NB];
      end
    end
  end

  assign out_if.valid       = vld_q;
  assign out_if.data        = out_q.data;
  assign out_if.datak       = out_q.datak;
  assign out_if.sync_header = out_q.sync_header;
endmodule

// File: tb/tb_tx_scrambler.sv
// Bench for tx_scrambler: lanes 0 and 5 side by side, table vectors for
// Gen1/2 known keystream, model-driven Gen3, reset and disable sequences.
module tb_tx_scrambler;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] gen;
  logic [1:0] lfsr_sel;
  logic       pattern_reset;
  logic [3:0] advance, scrambling_enable;
  logic       scr_dis;

  tx_scrambler_if in_if ();
  tx_scrambler_if out0 ();
  tx_scrambler_if out5 ();

  tx_scrambler #(.LANE_NUM(0)) u_dut0 (
    .clk(clk), .reset(reset), .gen(gen), .lfsr_sel(lfsr_sel),
    .pattern_reset(pattern_reset), .advance(advance),
    .scrambling_enable(scrambling_enable),
`ifdef TX_SCR_DISABLE_EN
    .scr_disable(scr_dis),
`endif
    .in_if(in_if), .out_if(out0)
  );

  tx_scrambler #(.LANE_NUM(5)) u_dut5 (
    .clk(clk), .reset(reset), .gen(gen), .lfsr_sel(lfsr_sel),
    .pattern_reset(pattern_reset), .advance(advance),
    .scrambling_enable(scrambling_enable),
`ifdef TX_SCR_DISABLE_EN
    .scr_disable(scr_dis),
`endif
    .in_if(in_if), .out_if(out5)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  gen;
    logic [1:0]  lsel;
    logic        prst;
    logic [3:0]  adv, se, k;
    logic [1:0]  sh;
    logic [31:0] data, exp;
  } vec_t;

  typedef struct {
    logic [31:0] d0, d5;
    logic [3:0]  k;
    logic [1:0]  sh;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[$];
  logic [23:0] m_lfsr [2];
  logic [31:0] last0, last5;
  int          nvec = 0, nerr = 0;

  function automatic vec_t mk(logic vld, logic [2:0] g, logic [1:0] ls, logic prst,
                              logic [3:0] adv, logic [3:0] se, logic [3:0] k,
                              logic [1:0] sh, logic [31:0] data, logic [31:0] exp);
    vec_t v;
    v.vld = vld; v.gen = g; v.lsel = ls; v.prst = prst; v.adv = adv;
    v.se = se; v.k = k; v.sh = sh; v.data = data; v.exp = exp;
    return v;
  endfunction

  function automatic logic [23:0] seed(int li, logic [2:0] g);
    if (g < 3'd3) return 24'h00FFFF;
    return (li == 0) ? 24'h1DBFBC : 24'h19CFC9;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference scrambler, bit-serial over the active bytes
  task automatic mdl(input int li, input vec_t v, input logic dis, output logic [31:0] dout);
    int          n;
    logic [23:0] s, t;
    logic [7:0]  ks;
    logic        g3, sc;
    g3   = (v.gen >= 3'd3);
    n    = (v.lsel == 2'd0) ? 1 : (v.lsel == 2'd1) ? 2 : 4;
    s    = m_lfsr[li];
    dout = v.data;
    for (int i = 0; i < n; i++) begin
      t = s;
      for (int j = 0; j < 8; j++) begin
        ks[j] = g3 ? t[22] : t[15];
        t = g3 ? (((t << 1) & 24'h7FFFFF) ^ (t[22] ? 24'h210125 : 24'h0))
               : (((t << 1) & 24'h00FFFF) ^ (t[15] ? 24'h000039 : 24'h0));
      end
      sc = g3 ? v.se[i] : (v.adv[i] & ~v.k[i]);
      if (sc && !dis) dout[8*i +: 8] = v.data[8*i +: 8] ^ ks;
      if (v.adv[i]) s = t;
    end
    m_lfsr[li] = v.prst ? seed(li, v.gen) : s;
  endtask

  // Drive one cycle; expected results go on the scoreboard and are
  // compared when the registered output appears
  task automatic step(input vec_t v, input bit use_tbl);
    exp_t        e;
    logic [31:0] d0, d5;
    in_if.valid = v.vld; in_if.data = v.data; in_if.datak = v.k;
    in_if.sync_header = v.sh; gen = v.gen; lfsr_sel = v.lsel;
    pattern_reset = v.prst; advance = v.adv; scrambling_enable = v.se;
    if (v.vld) begin
      mdl(0, v, scr_dis, d0);
      mdl(1, v, scr_dis, d5);
      if (use_tbl) begin d0 = v.exp; d5 = v.exp; end
      e.d0 = d0; e.d5 = d5; e.k = v.k; e.sh = v.sh;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("out_valid", {30'd0, out0.valid, out5.valid}, 32'd3);
      chk("data_l0", out0.data, e.d0);
      chk("data_l5", out5.data, e.d5);
      chk("k_sh", {26'd0, out0.datak, out0.sync_header}, {26'd0, e.k, e.sh});
      last0 = e.d0; last5 = e.d5;
    end else begin
      chk("idle_valid", {30'd0, out0.valid, out5.valid}, 32'd0);
      chk("hold_l0", out0.data, last0);
      chk("hold_l5", out5.data, last5);
    end
  endtask

  // Reset with a valid word presented; reset must win
  task automatic do_reset(input logic [2:0] g);
    reset = 1'b1; gen = g; in_if.valid = 1'b1; in_if.data = 32'h5A5A5A5A;
    in_if.datak = 4'hF; in_if.sync_header = 2'b11; advance = 4'hF;
    pattern_reset = 1'b0; lfsr_sel = 2'd2; scrambling_enable = 4'hF;
    @(posedge clk); #1;
    chk("rst_valid", {30'd0, out0.valid, out5.valid}, 32'd0);
    chk("rst_data", out0.data | out5.data, 32'd0);
    chk("rst_k_sh", {26'd0, out0.datak | out5.datak, out0.sync_header | out5.sync_header}, 32'd0);
    reset = 1'b0; in_if.valid = 1'b0;
    m_lfsr[0] = seed(0, g); m_lfsr[1] = seed(1, g);
    sb.delete(); last0 = '0; last5 = '0;
  endtask

  initial begin
    vec_t v;
    scr_dis = 1'b0; pattern_reset = 1'b0; advance = '0; scrambling_enable = '0;
    lfsr_sel = '0; gen = 3'd1; in_if.valid = 1'b0; in_if.data = '0;
    in_if.datak = '0; in_if.sync_header = '0; reset = 1'b1;
    @(posedge clk);
    do_reset(3'd1);

    // Gen1 known keystream FF 17 C0 14 B2 E7 02 82 ...
    tbl.push_back(mk(1, 1, 0, 0, 4'hF, 0, 0, 2'b01, 32'hA5A5A500, 32'hA5A5A5FF));
    tbl.push_back(mk(1, 1, 0, 0, 4'hF, 0, 0, 2'b10, 32'hA5A5A500, 32'hA5A5A517));
    tbl.push_back(mk(1, 1, 0, 0, 4'hF, 0, 0, 2'b01, 32'hA5A5A500, 32'hA5A5A5C0));
    tbl.push_back(mk(1, 1, 0, 0, 4'hF, 0, 0, 2'b10, 32'hA5A5A500, 32'hA5A5A514));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 0, 4'hF, 0, 0, 2'b00, 32'hFFFFFFFF, 32'h0));
    tbl.push_back(mk(1, 1, 0, 0, 4'hF, 0, 0, 2'b01, 32'hA5A5A500, 32'hA5A5A5B2));
    tbl.push_back(mk(1, 1, 0, 0, 4'hF, 0, 0, 2'b10, 32'hA5A5A500, 32'hA5A5A5E7));
    tbl.push_back(mk(1, 1, 0, 0, 4'hF, 0, 0, 2'b01, 32'hA5A5A500, 32'hA5A5A502));
    tbl.push_back(mk(1, 1, 0, 1, 4'hF, 0, 0, 2'b10, 32'hA5A5A500, 32'hA5A5A582));
    // 32-bit words from the seed
    tbl.push_back(mk(1, 1, 2, 0, 4'hF, 0, 0, 2'b00, 32'h0, 32'h14C017FF));
    tbl.push_back(mk(1, 1, 2, 1, 4'hF, 0, 0, 2'b00, 32'h0, 32'h8202E7B2));
    // SKP ordered set: COM advances, SKPs do not, all K pass through
    tbl.push_back(mk(1, 1, 2, 1, 4'h1, 0, 4'hF, 2'b00, 32'h1C1C1CBC, 32'h1C1C1CBC));
    tbl.push_back(mk(1, 1, 2, 1, 4'hF, 0, 0, 2'b00, 32'h0, 32'h14C017FF));
    // K byte advances but is not scrambled
    tbl.push_back(mk(1, 1, 2, 1, 4'hF, 0, 4'h1, 2'b00, 32'h0, 32'h14C01700));
    // 16-bit PIPE: upper bytes untouched, stream continues across words
    tbl.push_back(mk(1, 2, 1, 0, 4'hF, 0, 0, 2'b00, 32'h0, 32'h000017FF));
    tbl.push_back(mk(1, 2, 1, 1, 4'hF, 0, 0, 2'b00, 32'h0, 32'h000014C0));
    tbl.push_back(mk(1, 1, 2, 1, 4'hF, 0, 0, 2'b00, 32'hAA551234, 32'hBE9505CB));
    // lfsr_sel=3 behaves as 32-bit
    tbl.push_back(mk(1, 1, 3, 1, 4'hF, 0, 0, 2'b00, 32'h0, 32'h14C017FF));
    // SKP in byte 2: not scrambled, byte 3 picks up where byte 1 left off
    tbl.push_back(mk(1, 1, 2, 1, 4'hB, 0, 0, 2'b00, 32'h0, 32'hC00017FF));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);
    step(mk(0, 1, 2, 0, 4'hF, 0, 0, 0, 32'h0, 32'h0), 1'b0);

    // Gen3 lanes 0 and 5: zero data, K flags ignored
    do_reset(3'd3);
    for (int i = 0; i < 64; i++)
      step(mk(1, 3, 2, 0, 4'hF, 4'hF, 4'($urandom_range(0, 15)), 2'b01, 32'h0, 32'h0), 1'b0);
    // scrambling disabled word: passes through but the LFSR still advances
    v = mk(1, 3, 2, 0, 4'hF, 4'h0, 0, 2'b10, 32'hDEADBEEF, 32'h0);
    step(v, 1'b0);
    chk("g3_noscr", out0.data, 32'hDEADBEEF);
    for (int i = 0; i < 4; i++)
      step(mk(1, 3, 2, 0, 4'hF, 4'hF, 0, 2'b01, $urandom, 32'h0), 1'b0);
    step(mk(1, 3, 2, 0, 4'h7, 4'h5, 0, 2'b01, $urandom, 32'h0), 1'b0);
    step(mk(1, 3, 0, 1, 4'hF, 4'hF, 0, 2'b01, $urandom, 32'h0), 1'b0);
    step(mk(1, 3, 2, 0, 4'hF, 4'hF, 0, 2'b10, 32'h0, 32'h0), 1'b0);

    // Gen1 stream, then reset mid-stream with a valid word present
    do_reset(3'd1);
    for (int i = 0; i < 3; i++)
      step(mk(1, 1, 2, 0, 4'hF, 0, 0, 0, $urandom, 32'h0), 1'b0);
    do_reset(3'd1);
    step(mk(1, 1, 0, 0, 4'h1, 0, 0, 0, 32'h0, 32'h0), 1'b0);
    chk("rst_ks", {24'd0, out0.data[7:0]}, 32'h000000FF);

`ifdef TX_SCR_DISABLE_EN
    do_reset(3'd1);
    scr_dis = 1'b1;
    step(mk(1, 1, 2, 0, 4'hF, 0, 0, 0, 32'h01234567, 32'h0), 1'b0);
    chk("dis_w0", out0.data, 32'h01234567);
    step(mk(1, 1, 2, 0, 4'hF, 0, 0, 0, 32'h89ABCDEF, 32'h0), 1'b0);
    chk("dis_w1", out0.data, 32'h89ABCDEF);
    scr_dis = 1'b0;
    step(mk(1, 1, 2, 0, 4'hF, 0, 0, 0, 32'h0, 32'h0), 1'b0);
    step(mk(0, 1, 2, 0, 4'hF, 0, 0, 0, 32'h0, 32'h0), 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
